// File: rtl/shift_result_reg.sv
// Two-entry output buffer for a left shifter.
// Each accepted entry stores the shifter result together with its {N,Z,C,V}
// flags, which are computed from the same-cycle src/amt/result at push time.
//
// Ports:
//   clk        single clock, all state updates on the rising edge
//   rst_n      synchronous active-low reset
//   in_valid   upstream result valid
//   in_ready   buffer can accept an entry (decoded from registered state)
//   src        unshifted operand fed to the shifter
//   amt        unsigned shift amount fed to the shifter
//   result     shifter output for src, amt
//   out_valid  out/flags hold a valid entry
//   out_ready  downstream accepts the current entry
//   out        registered shift result (head entry)
//   flags      {N,Z,C,V} of the head entry
module shift_result_reg #(
  parameter int unsigned Nbits = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [Nbits-1:0] src,
  input  logic [Nbits-1:0] amt,
  input  logic [Nbits-1:0] result,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [Nbits-1:0] out,
  output logic [3:0]       flags
);

  typedef enum logic [1:0] {
    StEmpty,
    StOne,
    StFull
  } state_e;

  state_e           state_q;
  logic [Nbits-1:0] head_res_q;
  logic [3:0]       head_flags_q;
  logic [Nbits-1:0] tail_res_q;
  logic [3:0]       tail_flags_q;

  logic             carry;
  logic [3:0]       new_flags;
  logic             push;
  logic             pop;

  // Last bit shifted out: src[Nbits-amt] for 1 <= amt <= Nbits, else 0.
  always_comb begin
    carry = 1'b0;
    for (int unsigned i = 1; i <= Nbits; i++) begin
      if (amt == Nbits'(i)) begin
        carry = src[Nbits-i];
      end
    end
  end

  always_comb begin
    new_flags = {result[Nbits-1],
                 (result == '0),
                 carry,
                 result[Nbits-1] ^ src[Nbits-1]};
  end

  // Handshake decode uses registered state only, so in_ready has no path
  // from out_ready.
  assign in_ready  = (state_q != StFull);
  assign out_valid = (state_q != StEmpty);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  assign out   = head_res_q;
  assign flags = head_flags_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= StEmpty;
      head_res_q   <= '0;
      head_flags_q <= '0;
      tail_res_q   <= '0;
      tail_flags_q <= '0;
    end else begin
      case (state_q)
        StEmpty: begin
          if (push) begin
            head_res_q   <= result;
            head_flags_q <= new_flags;
            state_q      <= StOne;
          end
        end
        StOne: begin
          if (push && pop) begin
            // Head retires and the new entry replaces it directly.
            head_res_q   <= result;
            head_flags_q <= new_flags;
          end else if (push) begin
            tail_res_q   <= result;
            tail_flags_q <= new_flags;
            state_q      <= StFull;
          end else if (pop) begin
            // Head keeps the retired value while empty.
            state_q <= StEmpty;
          end
        end
        StFull: begin
          if (pop) begin
            head_res_q   <= tail_res_q;
            head_flags_q <= tail_flags_q;
            state_q      <= StOne;
          end
        end
        default: begin
          state_q <= StEmpty;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shift_result_reg.sv
module tb_shift_result_reg;

  localparam int unsigned N = 4;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] src;
  logic [N-1:0] amt;
  logic [N-1:0] result;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] out;
  logic [3:0]   flags;

  int total;
  int bad;

  // Reference model: queue of {result, flags} entries, plus last retired entry.
  logic [N+3:0] mq[$];
  logic [N+3:0] last;

  shift_result_reg #(.Nbits(N)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .src      (src),
    .amt      (amt),
    .result   (result),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out      (out),
    .flags    (flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] ref_flags(input int s, input int a, input int r);
    int n, z, c, v;
    n = (r >> (N - 1)) & 1;
    z = (r == 0) ? 1 : 0;
    if (a == 0 || a > int'(N)) c = 0;
    else c = (s >> (int'(N) - a)) & 1;
    v = n ^ ((s >> (N - 1)) & 1);
    return 4'((n << 3) | (z << 2) | (c << 1) | v);
  endfunction

  function automatic logic [N-1:0] ref_shift(input int s, input int a);
    if (a >= int'(N)) return '0;
    return N'((s << a) & ((1 << N) - 1));
  endfunction

  task automatic check_outputs();
    logic [N+3:0] shown;
    shown = (mq.size() > 0) ? mq[0] : last;
    check_eq("in_ready", 32'(in_ready), 32'(mq.size() < 2));
    check_eq("out_valid", 32'(out_valid), 32'(mq.size() > 0));
    check_eq("out", 32'(out), 32'(shown[N+3:4]));
    check_eq("flags", 32'(flags), 32'(shown[3:0]));
  endtask

  // One clock: drive inputs, update the model at the edge, check half a cycle later.
  task automatic cycle(input logic rn, input logic iv, input logic [N-1:0] s,
                       input logic [N-1:0] a, input logic [N-1:0] r, input logic ordy);
    logic do_push, do_pop;
    rst_n     = rn;
    in_valid  = iv;
    src       = s;
    amt       = a;
    result    = r;
    out_ready = ordy;
    @(posedge clk);
    if (!rn) begin
      mq.delete();
      last = '0;
    end else begin
      do_push = iv && (mq.size() < 2);
      do_pop  = ordy && (mq.size() > 0);
      if (do_pop) last = mq.pop_front();
      if (do_push) mq.push_back({r, ref_flags(int'(s), int'(a), int'(r))});
    end
    @(negedge clk);
    check_outputs();
  endtask

  initial begin
    logic [N-1:0] s, a, r;
    logic iv, held;
    total = 0;
    bad   = 0;
    last  = '0;
    rst_n = 1'b0; in_valid = 1'b0; src = '0; amt = '0; result = '0; out_ready = 1'b0;

    // Reset for two cycles with in_valid high.
    cycle(1'b0, 1'b1, 4'b0011, 4'b0001, 4'b0110, 1'b0);
    cycle(1'b0, 1'b1, 4'b0011, 4'b0001, 4'b0110, 1'b0);
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_out", 32'(out), 32'd0);
    check_eq("rst_flags", 32'(flags), 32'd0);
    check_eq("rst_in_ready", 32'(in_ready), 32'd1);

    // Plain push, then drains one cycle later.
    cycle(1'b1, 1'b1, 4'b0011, 4'b0001, 4'b0110, 1'b1);
    check_eq("plain_out", 32'(out), 32'h6);
    check_eq("plain_flags", 32'(flags), 32'h0);
    cycle(1'b1, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b1);
    check_eq("plain_drained", 32'(out_valid), 32'd0);
    check_eq("plain_hold", 32'(out), 32'h6);

    // Carry and overflow.
    cycle(1'b1, 1'b1, 4'b1001, 4'b0001, 4'b0010, 1'b1);
    check_eq("cv_out", 32'(out), 32'h2);
    check_eq("cv_flags", 32'(flags), 32'b0011);

    // Over-range shift amount.
    cycle(1'b1, 1'b1, 4'b1111, 4'b0101, 4'b0000, 1'b1);
    check_eq("ovr_flags", 32'(flags), 32'b0101);
    cycle(1'b1, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b1);

    // Backpressure: three pushes with out_ready low, third is held.
    cycle(1'b1, 1'b1, 4'b0001, 4'b0001, 4'b0010, 1'b0);
    cycle(1'b1, 1'b1, 4'b0001, 4'b0010, 4'b0100, 1'b0);
    check_eq("bp_full_in_ready", 32'(in_ready), 32'd0);
    cycle(1'b1, 1'b1, 4'b0001, 4'b0011, 4'b1000, 1'b0);
    check_eq("bp_head_stable", 32'(out), 32'h2);
    cycle(1'b1, 1'b1, 4'b0001, 4'b0011, 4'b1000, 1'b1);
    check_eq("bp_second", 32'(out), 32'h4);
    cycle(1'b1, 1'b1, 4'b0001, 4'b0011, 4'b1000, 1'b1);
    check_eq("bp_third", 32'(out), 32'h8);
    cycle(1'b1, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b1);
    check_eq("bp_empty", 32'(out_valid), 32'd0);

    // Reset while full discards both entries.
    cycle(1'b1, 1'b1, 4'b0001, 4'b0000, 4'b0001, 1'b0);
    cycle(1'b1, 1'b1, 4'b0011, 4'b0000, 4'b0011, 1'b0);
    cycle(1'b0, 1'b1, 4'b0111, 4'b0000, 4'b0111, 1'b1);
    check_eq("rf_out_valid", 32'(out_valid), 32'd0);
    check_eq("rf_in_ready", 32'(in_ready), 32'd1);
    check_eq("rf_out", 32'(out), 32'd0);
    cycle(1'b1, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b1);
    check_eq("rf_no_ghost", 32'(out_valid), 32'd0);

    // Randomized traffic; upstream holds data while not accepted.
    held = 1'b0;
    s = '0; a = '0; r = '0; iv = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      logic rn, ordy;
      rn   = ($urandom_range(0, 63) != 0);
      ordy = ($urandom_range(0, 2) != 0);
      if (!held) begin
        iv = ($urandom_range(0, 3) != 0);
        s  = N'($urandom);
        a  = ($urandom_range(0, 1) != 0) ? N'($urandom_range(0, N + 1)) : N'($urandom);
        r  = ($urandom_range(0, 7) == 0) ? N'($urandom) : ref_shift(int'(s), int'(a));
      end
      held = rn && iv && (mq.size() >= 2);
      cycle(rn, iv, s, a, r, ordy);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/shift_result_reg.md
SHIFT_RESULT_REG -- requirements
Module: SHIFT_RESULT_REG

Interface
REQ-001 SHALL have parameter: Nbits, default 4, datapath width of operand, shift amount and result.
REQ-002 SHALL have port: CLK  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: RST_N  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port: IN_VALID  input  1  upstream shifter result valid.
REQ-005 SHALL have port: IN_READY  output  1  block can accept an input this cycle.
REQ-006 SHALL have port: SRC  input  Nbits  unshifted operand A fed to the left shifter.
REQ-007 SHALL have port: AMT  input  Nbits  shift amount B fed to the left shifter (unsigned).
REQ-008 SHALL have port: RESULT  input  Nbits  left-shifter output for SRC, AMT.
REQ-009 SHALL have port: OUT_VALID  output  1  OUT/FLAGS hold a valid entry.
REQ-010 SHALL have port: OUT_READY  input  1  downstream accepts current entry.
REQ-011 SHALL have port: OUT  output  Nbits  registered shift result.
REQ-012 SHALL have port: FLAGS  output  4  {N,Z,C,V} for the entry on OUT.

Function
REQ-013 SHALL accept an input on a rising edge where IN_VALID=1 and IN_READY=1 (push), and retire an entry on a rising edge where OUT_VALID=1 and OUT_READY=1 (pop).
REQ-014 SHALL buffer up to 2 entries in FIFO order; each entry = RESULT plus its computed FLAGS.
REQ-015 SHALL use state machine EMPTY/ONE/FULL: EMPTY -push-> ONE; ONE -push only-> FULL; ONE -pop only-> EMPTY; ONE -push+pop-> ONE; FULL -pop-> ONE; all other cases hold state.
REQ-016 SHALL drive IN_READY=1 in EMPTY and ONE, 0 in FULL, decoded from registered state only (no combinational path from OUT_READY).
REQ-017 SHALL drive OUT_VALID=1 in ONE and FULL, 0 in EMPTY.
REQ-018 SHALL present a pushed entry on OUT/FLAGS on the cycle after the push when the buffer was EMPTY (latency 1 cycle).
REQ-019 SHALL, on push+pop in ONE, present the newly pushed entry on the next cycle.
REQ-020 SHALL hold OUT and FLAGS stable while OUT_VALID=1 and OUT_READY=0.
REQ-021 SHALL hold OUT/FLAGS at the last retired value while EMPTY.
REQ-022 SHALL ignore IN_VALID when IN_READY=0; the upstream holds its data (no drop, no overwrite).
REQ-023 SHALL compute N = RESULT[Nbits-1].
REQ-024 SHALL compute Z = 1 iff RESULT equals 0.
REQ-025 SHALL compute C as the last bit shifted out: 0 if AMT=0; SRC[Nbits-AMT] if 1<=AMT<=Nbits; 0 if AMT>Nbits.
REQ-026 SHALL compute V = RESULT[Nbits-1] XOR SRC[Nbits-1] (sign change).
REQ-027 SHALL compute flags at push time from the input-cycle SRC/AMT/RESULT, not at pop time.
REQ-028 SHALL treat AMT fully unsigned across all Nbits bits; AMT values up to 2**Nbits-1 are legal.

Reset
REQ-029 SHALL, on a rising edge with RST_N=0, set state EMPTY, OUT=0, FLAGS=0, OUT_VALID=0.
REQ-030 SHALL discard all buffered entries on reset mid-operation, regardless of IN_VALID/OUT_READY during that edge.
REQ-031 SHALL drive IN_READY=1 from the first cycle after reset release (state EMPTY).
REQ-032 SHALL ignore pushes and pops on any edge where RST_N=0.

Verification (Nbits=4)
REQ-033 SHALL cover reset: RST_N=0 for 2 cycles, IN_VALID=1 -> OUT_VALID=0, OUT=0000, FLAGS=0000, IN_READY=1 after release.
REQ-034 SHALL cover a plain push: SRC=0011, AMT=0001, RESULT=0110, OUT_READY=1 -> next cycle OUT_VALID=1, OUT=0110, FLAGS N0 Z0 C0 V0; EMPTY one cycle later.
REQ-035 SHALL cover carry/overflow: SRC=1001, AMT=0001, RESULT=0010 -> OUT=0010, N0 Z0 C1 V1.
REQ-036 SHALL cover over-range shift: SRC=1111, AMT=0101, RESULT=0000 -> N0 Z1 C0 V1.
REQ-037 SHALL cover backpressure: OUT_READY=0, three back-to-back pushes (0010, 0100, 1000) -> IN_READY=0 after second push, third held; OUT_READY=1 -> pops 0010, 0100, then 1000, order preserved, no loss.
REQ-038 SHALL cover reset while FULL: RST_N=0 for one edge -> OUT_VALID=0, IN_READY=1, OUT=0000, buffered entries never appear.
